// File: rtl/prio_enc_arb_pkg.sv
// Shared constants and types for the registered priority encoder / arbiter.
package prio_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/prio_enc_arb_scan.sv
// Combinational downward search of a request vector, starting at base_i and
// wrapping from 0 to N-1. Reports the first set index encountered.
module prio_scan import prio_pkg::*; #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] base_i,
  output logic                 found_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int W = $clog2(N);

  logic [W-1:0] pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = base_i;
    for (int i = 0; i < N; i++) begin
      if (!found_o && req_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
      pos = (pos == '0) ? W'(N - 1) : pos - W'(1);
    end
  end

endmodule

// File: rtl/prio_enc_arb.sv
// Registered N-way priority encoder with fixed or round-robin arbitration and
// a single-entry valid/ready output stage.
//
//   state | meaning
//   EMPTY | no entry held; capture when en && |req
//   FULL  | entry on outputs; refill on handshake, hold while stalled
module prio_enc_arb import prio_pkg::*; #(
  parameter int N    = 8,
  parameter int MODE = MODE_FIXED
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 busy
);

  localparam int           W   = $clog2(N);
  localparam logic [N-1:0] ONE = N'(1);

  state_e       state_q, state_d;
  logic [W-1:0] idx_q;
  logic [N-1:0] onehot_q;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;

  logic [W-1:0] base;
  logic         scan_found;
  logic [W-1:0] scan_idx;
  logic         capture;

  // Fixed priority is a round-robin search that always starts at the top.
  assign base = (MODE == MODE_RR) ? rr_ptr_q : W'(N - 1);

  prio_scan #(.N(N)) u_scan (
    .req_i   (req),
    .base_i  (base),
    .found_o (scan_found),
    .idx_o   (scan_idx)
  );

  assign capture  = en && scan_found && ((state_q == EMPTY) || out_ready);
  assign state_d  = capture ? FULL : (out_ready ? EMPTY : state_q);
  assign rr_ptr_d = (scan_idx == '0) ? W'(N - 1) : scan_idx - W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      idx_q    <= '0;
      onehot_q <= '0;
      rr_ptr_q <= W'(N - 1);
    end else begin
      state_q <= state_d;
      if (capture) begin
        idx_q    <= scan_idx;
        onehot_q <= ONE << scan_idx;
        if (MODE == MODE_RR) rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign busy       = out_valid && !out_ready;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Scoreboard bench: a fixed-priority and a round-robin instance share stimulus;
// a reference model queues expected grants, a negedge monitor checks them.
module tb_prio_enc_arb;

  localparam int N = 8;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] req;
  logic         out_ready;

  logic         dv [2];
  logic [W-1:0] di [2];
  logic [N-1:0] doh[2];
  logic         db [2];

  int checks = 0;
  int errors = 0;

  int unsigned expq[2][$];
  bit          mfull[2];
  bit          cur_full[2];
  int          last_grant[2];

  always #5 clk = ~clk;

  prio_enc_arb #(.N(N), .MODE(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(dv[0]), .out_idx(di[0]), .out_onehot(doh[0]), .busy(db[0])
  );

  prio_enc_arb #(.N(N), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(dv[1]), .out_idx(di[1]), .out_onehot(doh[1]), .busy(db[1])
  );

  task automatic chk(input string name, input int m, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0d expected=%0d t=%0t", name, m, act, exp, $time);
    end
  endtask

  // Reference: fixed = highest set bit; round-robin = first set bit strictly
  // below the previous grant, going around the ring.
  function automatic int winner(input int m, input logic [N-1:0] r, input int last);
    if (m == 0) begin
      for (int i = N - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c = (last - k + N) % N;
        if (r[c]) return c;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      expq[m].delete();
      mfull[m]      = 1'b0;
      cur_full[m]   = 1'b0;
      last_grant[m] = 0;
    end
  endtask

  // Called just after a rising edge: drive one cycle of inputs and predict.
  task automatic step(input bit e, input logic [N-1:0] r, input bit rd);
    for (int m = 0; m < 2; m++) cur_full[m] = mfull[m];
    en        = e;
    req       = r;
    out_ready = rd;
    for (int m = 0; m < 2; m++) begin
      if (e && (r != 0) && (!mfull[m] || rd)) begin
        int w = winner(m, r, last_grant[m]);
        expq[m].push_back(w);
        last_grant[m] = w;
        mfull[m] = 1'b1;
      end else if (mfull[m] && rd) begin
        mfull[m] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int m = 0; m < 2; m++) begin
        chk("out_valid", m, dv[m], cur_full[m]);
        chk("busy", m, db[m], cur_full[m] && !out_ready);
        if (dv[m]) begin
          if (expq[m].size() == 0) begin
            chk("unexpected_entry", m, 1, 0);
          end else begin
            chk("out_idx", m, di[m], expq[m][0]);
            chk("out_onehot", m, doh[m], longint'(1) << expq[m][0]);
            if (out_ready) void'(expq[m].pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0; out_ready = 1'b0;
    model_reset();
    #3;
    for (int m = 0; m < 2; m++) begin
      chk("rst_valid", m, dv[m], 0);
      chk("rst_idx", m, di[m], 0);
      chk("rst_onehot", m, doh[m], 0);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // first capture, then a three-cycle stall with changing requests
    step(1, 8'h16, 1);
    repeat (3) step(1, 8'h80, 0);
    step(1, 8'h80, 1);
    step(0, 8'h00, 1);

    // full request vector: rotation in round-robin, constant 7 in fixed
    repeat (9) step(1, 8'hFF, 1);
    step(0, 8'h00, 1);

    // two-requester fairness
    repeat (4) step(1, 8'h81, 1);
    step(0, 8'h00, 1);

    // boundaries: no requests, disabled capture, drain with en low
    repeat (2) step(1, 8'h00, 1);
    repeat (2) step(0, 8'hFF, 1);
    step(1, 8'hFF, 1);
    step(0, 8'hFF, 1);
    step(0, 8'hFF, 1);

    // async reset while stalled on index 5
    step(1, 8'h20, 1);
    step(1, 8'hFF, 0);
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("midstall_rst_valid", m, dv[m], 0);
      chk("midstall_rst_onehot", m, doh[m], 0);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1, 8'hFF, 1);
    step(1, 8'hFF, 1);
    step(0, 8'h00, 1);

    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      r = N'($urandom);
      if ($urandom_range(0, 5) == 0) r = '0;
      else if ($urandom_range(0, 3) == 0) r = r & N'($urandom);
      step($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0);
    end
    repeat (3) step(0, 8'h00, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_enc_arb.md
Name: prio_enc_arb

Overview:
- Parametrised, registered successor to the team's 8-to-3 structural priority encoder.
- Samples an N-bit request vector and encodes the winning request index.
- Selects the winner by fixed priority (highest index wins) or by round-robin priority.
- Presents the result on a valid/ready output stage that holds one entry; sits between request sources (interrupt lines, channel requests) and a downstream consumer that can stall.

Parameters:
- N, 8, number of request lines (2..64).
- W, $clog2(N), width of the encoded index; derived, not overridden.
- MODE, 0, arbitration mode: 0 = fixed priority (highest index wins), 1 = round-robin.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when low, no new capture, but a held entry is retained.
- req  input  N  level request vector, sampled every cycle.
- out_ready  input  1  downstream accepts the entry when out_valid && out_ready.
- out_valid  output  1  out_idx/out_onehot hold a valid encoded winner.
- out_idx  output  W  encoded index of the winning request.
- out_onehot  output  N  one-hot form of out_idx.
- busy  output  1  out_valid && !out_ready, i.e. stall indicator (combinational).

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_idx=0, out_onehot=0.
  - State EMPTY; rr_ptr=N-1.
- State machine, two states:
  - EMPTY: if en && |req, capture the winner next edge and go to FULL; else stay.
  - FULL:
    - out_valid=1.
    - If out_ready && en && |req, capture the new winner in the same edge and stay FULL (1 result per cycle).
    - If out_ready and no capture, go to EMPTY.
    - If !out_ready, hold out_idx/out_onehot bit-stable regardless of req or en.
- Latency: req sampled at edge k appears on outputs after edge k (1 cycle). No combinational path from req to outputs.
- Fixed mode (MODE=0): winner = highest set index of req. Matches the 8-to-3 truth table for N=8.
- Round-robin mode (MODE=1):
  - Search order is rr_ptr, rr_ptr-1, ..., 0, N-1, ..., rr_ptr+1.
  - rr_ptr updates only on capture: rr_ptr = (winner==0) ? N-1 : winner-1.
  - Reset value N-1 makes the first grant identical to fixed mode.
- Request deassertion while FULL does not affect the held entry; requests are not remembered across cycles.
- en low in FULL: entry still drains on out_ready; no refill.
- req=0 with en=1: no capture; out_idx keeps its last value while out_valid=0.
- Width rule: out_idx is zero-extended encoding; for non-power-of-2 N, indices >= N never appear.
- out_onehot == (1 << out_idx) whenever out_valid=1, and 0 after reset.
- Reset asserted mid-stall drops the entry immediately (out_valid=0 asynchronously).

Decomposition:
- Package prio_pkg:
  - MODE_FIXED=0, MODE_RR=1 constants.
  - Typedef for the state enum {EMPTY, FULL}.
- Sub-module prio_scan (purely combinational, parameter N):
  - Inputs: req[N-1:0], base[W-1:0].
  - Outputs: found, idx[W-1:0].
  - Scans downward from base with wrap. Fixed mode ties base to N-1.
- Top holds the state register, the output register and rr_ptr.

Test Plan:
- Fixed, N=8: req=8'b0001_0110, en=1, out_ready=1 -> after 1 edge out_valid=1, out_idx=4, out_onehot=8'h10.
- Stall: entry out_idx=4 held, out_ready=0 for 3 cycles while req changes to 8'h80 -> out_idx stays 4; busy=1. Raise out_ready -> next edge out_idx=7.
- RR, N=8: req=8'hFF held, out_ready=1 -> grant sequence 7,6,5,4,3,2,1,0,7 (wrap); rr_ptr=7 after grant 0.
- RR fairness: req=8'b1000_0001 constant -> grants alternate 7,0,7,0.
- Boundaries: req=0 -> out_valid stays 0. en=0 with req=8'hFF -> no capture. en=0 while FULL with out_ready=1 -> out_valid falls next edge.
- Async reset mid-stall: FULL with out_idx=5, assert rst_n=0 between edges -> out_valid=0, out_onehot=0 immediately. After release, first RR grant uses rr_ptr=7.
